// File: rtl/bch_serial_encoder_if.sv
// Stream bundle for the BCH(63,51) serial encoder.
//
// Purpose: groups the serial handshake (ready/valid/data in both directions)
// and the parallel codeword bus so the encoder and its environment connect
// through a single port.
//
// Signals:
//   ready_in      downstream can take a data_out bit this cycle
//   ready_out     encoder accepts a data_in bit this cycle
//   valid_in      data_in carries a valid message bit
//   valid_out     data_out carries a valid codeword bit
//   data_in       serial message bit
//   data_out      serial codeword bit
//   data_in_all   parallel 51-bit message (parallel build only)
//   data_out_all  63-bit codeword {message, parity}
//
// Modports: slave = encoder side, master = source/sink side.
interface bch_serial_encoder_if;
    logic        ready_in;
    logic        ready_out;
    logic        valid_in;
    logic        valid_out;
    logic        data_in;
    logic        data_out;
    logic [50:0] data_in_all;
    logic [62:0] data_out_all;

    modport slave (
        input  ready_in, valid_in, data_in, data_in_all,
        output ready_out, valid_out, data_out, data_out_all
    );

    modport master (
        output ready_in, valid_in, data_in, data_in_all,
        input  ready_out, valid_out, data_out, data_out_all
    );
endinterface

// File: rtl/bch_serial_encoder.sv
// Systematic BCH(63,51) serial encoder, t=2,
// g(x) = x^12 + x^10 + x^8 + x^5 + x^4 + x^3 + 1.
//
// Purpose: accepts a 51-bit message serially (MSB first) and emits the
// 63-bit codeword serially: the 51 message bits followed by the 12 parity
// bits, MSB first. Each codeword bit leaves one cycle after the edge that
// produced it, with a one-cycle valid_out pulse. The last completed codeword
// is also presented in parallel on data_out_all.
//
// Ports:
//   clk   in  single clock, all logic on posedge
//   rst   in  asynchronous reset, active-low
//   bus   slave modport of bch_serial_encoder_if (serial handshake and
//         parallel codeword bus)
//
// Configuration macro BCH_PARALLEL_EN:
//   defined   - data_out_all = {data_in_all, parity(data_in_all)},
//               combinational; the serial path is unchanged.
//   undefined - data_in_all is ignored; data_out_all holds the last
//               codeword completed on the serial path.
module bch_serial_encoder (
    input  logic                 clk,
    input  logic                 rst,
    bch_serial_encoder_if.slave  bus
);

    // Low 12 coefficients of g(x); the x^12 term is the bit shifted out.
    localparam logic [11:0] GEN_LOW = 12'h539;

    typedef enum logic {
        MSG,
        PAR
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q,   cnt_d;
    logic [11:0] lfsr_q,  lfsr_d;
    logic [11:0] par_q,   par_d;
    logic [50:0] msg_q,   msg_d;
    logic        dout_q,  dout_d;
    logic        vld_q,   vld_d;
    logic [62:0] all_q,   all_d;
    logic        accept;

    // One step of the division LFSR: feedback is the incoming bit XOR the
    // register MSB, and the generator is folded in when the feedback is set.
    function automatic logic [11:0] lfsr_step(input logic [11:0] s, input logic b);
        logic fb;
        fb = b ^ s[11];
        return {s[10:0], 1'b0} ^ (fb ? GEN_LOW : 12'h000);
    endfunction

    // Fully unrolled division of a whole message, MSB first.
    function automatic logic [11:0] par_of(input logic [50:0] m);
        logic [11:0] s;
        s = 12'h000;
        for (int i = 50; i >= 0; i--) begin
            s = lfsr_step(s, m[i]);
        end
        return s;
    endfunction

    assign bus.ready_out = (state_q == MSG) ? bus.ready_in : 1'b0;
    assign accept        = (state_q == MSG) && bus.valid_in && bus.ready_in;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        par_d   = par_q;
        msg_d   = msg_q;
        dout_d  = dout_q;
        vld_d   = 1'b0;
        all_d   = all_q;

        case (state_q)
            MSG: begin
                if (accept) begin
                    lfsr_d = lfsr_step(lfsr_q, bus.data_in);
                    dout_d = bus.data_in;
                    vld_d  = 1'b1;
                    msg_d  = {msg_q[49:0], bus.data_in};
                    if (cnt_q == 6'd50) begin
                        // Remainder is final here; keep a copy because the
                        // LFSR is consumed while shifting the parity out.
                        par_d   = lfsr_d;
                        cnt_d   = 6'd0;
                        state_d = PAR;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            PAR: begin
                if (bus.ready_in) begin
                    dout_d = lfsr_q[11];
                    lfsr_d = {lfsr_q[10:0], 1'b0};
                    vld_d  = 1'b1;
                    if (cnt_q == 6'd11) begin
                        all_d   = {msg_q, par_q};
                        lfsr_d  = 12'h000;
                        cnt_d   = 6'd0;
                        state_d = MSG;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = MSG;
                cnt_d   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MSG;
            cnt_q   <= 6'd0;
            lfsr_q  <= 12'h000;
            par_q   <= 12'h000;
            msg_q   <= 51'd0;
            dout_q  <= 1'b0;
            vld_q   <= 1'b0;
            all_q   <= 63'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            par_q   <= par_d;
            msg_q   <= msg_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            all_q   <= all_d;
        end
    end

    assign bus.data_out  = dout_q;
    assign bus.valid_out = vld_q;

`ifdef BCH_PARALLEL_EN
    logic unused_all;
    assign unused_all       = ^all_q;
    assign bus.data_out_all = {bus.data_in_all, par_of(bus.data_in_all)};
`else
    logic unused_in_all;
    assign unused_in_all    = ^bus.data_in_all;
    assign bus.data_out_all = all_q;
`endif

endmodule

// File: tb/tb_bch_serial_encoder.sv
// Bench for bch_serial_encoder: randomized handshake stimulus compared
// against a polynomial long-division reference model.
module tb_bch_serial_encoder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bch_serial_encoder_if bus();

    bch_serial_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [50:0] msgs [8];
    logic        exp_vld;
    logic        exp_dout;
    logic [62:0] exp_all;

    task automatic check_val(input string tag, input logic [62:0] obs, input logic [62:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Remainder of m(x)*x^12 divided by g(x), by plain GF(2) long division.
    function automatic logic [11:0] ref_par(input logic [50:0] m);
        logic [62:0] r;
        logic [62:0] g;
        r = {m, 12'h000};
        g = 63'h1539;
        for (int i = 62; i >= 12; i--) begin
            if (r[i]) r = r ^ (g << (i - 12));
        end
        return r[11:0];
    endfunction

    task automatic check_obs();
        check_val("valid_out", 63'(bus.valid_out), 63'(exp_vld));
        check_val("data_out", 63'(bus.data_out), 63'(exp_dout));
`ifdef BCH_PARALLEL_EN
        check_val("codeword_par", bus.data_out_all, {bus.data_in_all, ref_par(bus.data_in_all)});
`else
        check_val("codeword", bus.data_out_all, exp_all);
`endif
    endtask

    // Streams msgs[0..nw-1] back to back. abort_at >= 0 returns once that
    // many bits of the first word have been accepted.
    task automatic run_stream(input int nw, input bit rnd_rdy, input bit rnd_vld, input int abort_at);
        int          wi = 0;
        int          sent = 0;
        int          par_left = 0;
        int          done = 0;
        int          cyc = 0;
        logic [11:0] p;
        logic        in_par;
        logic        exp_ro;
        logic        acc;
        logic        emit;
        while (done < nw && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            check_obs();
            if (abort_at >= 0 && wi == 0 && sent == abort_at) return;
            in_par          = (par_left > 0);
            bus.ready_in    = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.valid_in    = !in_par && (wi < nw) && (rnd_vld ? ($urandom_range(0, 3) != 0) : 1'b1);
            bus.data_in     = (!in_par && wi < nw) ? msgs[wi][50 - sent] : 1'b0;
            bus.data_in_all = msgs[(wi < nw) ? wi : nw - 1];
            #1;
            exp_ro = in_par ? 1'b0 : bus.ready_in;
            check_val("ready_out", 63'(bus.ready_out), 63'(exp_ro));
            acc     = bus.valid_in && exp_ro;
            emit    = in_par && bus.ready_in;
            exp_vld = acc || emit;
            if (acc) begin
                exp_dout = bus.data_in;
                if (sent == 50) begin
                    sent     = 0;
                    par_left = 12;
                end else begin
                    sent++;
                end
            end else if (emit) begin
                p        = ref_par(msgs[wi]);
                exp_dout = p[par_left - 1];
                par_left--;
                if (par_left == 0) begin
                    exp_all = {msgs[wi], p};
                    wi++;
                    done++;
                end
            end
        end
        check_val("stream_done", 63'(done), 63'(nw));
        @(negedge clk);
        check_obs();
        bus.valid_in = 1'b0;
        exp_vld      = 1'b0;
    endtask

    task automatic apply_reset();
        rst             = 1'b0;
        bus.valid_in    = 1'b0;
        bus.data_in_all = 51'd0;
        #1;
        check_val("rst_valid_out", 63'(bus.valid_out), 63'd0);
        check_val("rst_data_out", 63'(bus.data_out), 63'd0);
        check_val("rst_data_out_all", bus.data_out_all, 63'd0);
        exp_vld  = 1'b0;
        exp_dout = 1'b0;
        exp_all  = 63'd0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [50:0] lit_msg [4];
    logic [62:0] lit_cw  [4];

    initial begin
        lit_msg[0] = 51'h0; lit_cw[0] = {51'h0, 12'h000};
        lit_msg[1] = 51'h1; lit_cw[1] = {51'h1, 12'h539};
        lit_msg[2] = 51'h2; lit_cw[2] = {51'h2, 12'hA72};
        lit_msg[3] = 51'h3; lit_cw[3] = {51'h3, 12'hF4B};

        rst             = 1'b0;
        bus.ready_in    = 1'b0;
        bus.valid_in    = 1'b0;
        bus.data_in     = 1'b0;
        bus.data_in_all = 51'd0;
        exp_vld         = 1'b0;
        exp_dout        = 1'b0;
        exp_all         = 63'd0;

        repeat (2) @(negedge clk);
        apply_reset();
        bus.ready_in = 1'b1;
        #1;
        check_val("idle_ready_out", 63'(bus.ready_out), 63'd1);
        @(negedge clk);
        check_obs();

        // Known single-word codewords.
        for (int k = 0; k < 4; k++) begin
            msgs[0] = lit_msg[k];
            run_stream(1, 1'b0, 1'b0, -1);
            bus.data_in_all = lit_msg[k];
            #1;
            check_val("codeword_literal", bus.data_out_all, lit_cw[k]);
        end

        // Fixed pattern under random ready/valid stalls.
        msgs[0] = 51'b011011011110110110001111011001011110011001101100011;
        run_stream(1, 1'b1, 1'b1, -1);

        // Random words, back to back, with and without stalls.
        for (int k = 0; k < 4; k++) msgs[k] = {$urandom, $urandom};
        run_stream(4, 1'b1, 1'b1, -1);
        for (int k = 0; k < 3; k++) msgs[k] = {$urandom, $urandom};
        run_stream(3, 1'b0, 1'b0, -1);

        // Reset in the middle of a word, then a clean word.
        msgs[0] = {$urandom, $urandom};
        run_stream(1, 1'b0, 1'b0, 20);
        apply_reset();
        msgs[0] = 51'h1;
        run_stream(1, 1'b0, 1'b0, -1);
        bus.data_in_all = 51'h1;
        #1;
        check_val("after_reset_codeword", bus.data_out_all, {51'h1, 12'h539});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
